// File: rtl/alu_sequencer.sv
// alu_sequencer: single-stage command/response ALU with an accumulator.
//
// A command (funct, A, B) is accepted on a rising clk edge when
// cmd_valid && cmd_ready. Its response is registered on that same edge and
// presented on rsp_* until the consumer takes it with rsp_ready. A new
// command can be accepted on the same edge that drains the previous response.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  command can be taken (!rsp_valid || rsp_ready)
//   cmd_funct    in   [3:0] 0 ADD,1 SUB,2 SHFTL,3 SHFTR,4 AND,5 OR,6 XOR,
//                     7 NOT,15 CLR, 8-14 illegal
//   cmd_a, cmd_b in   [7:0] two's-complement operands
//   cmd_use_acc  in   use the accumulator instead of cmd_a as operand A
//   rsp_valid    out  response held
//   rsp_ready    in   consumer accepts the response
//   rsp_result   out  [7:0] result
//   rsp_carry, rsp_overflow, rsp_error  out  result flags
//   rsp_state    out  [1:0] FSM state after the command (0 READY,1 ARITH,
//                     2 LOGIC,3 ERROR)
//   acc          out  [7:0] accumulator
//   op_count     out  [7:0] drained-response counter, saturating at 255
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_funct,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic       rsp_error,
  output logic [1:0] rsp_state,
  output logic [7:0] acc,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_ARITH = 2'd1,
    ST_LOGIC = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;

  logic       accept;
  logic       drain;
  logic       illegal;
  logic [7:0] op_a;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_v;

  assign cmd_ready = !rsp_valid_q || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign drain     = rsp_valid_q && rsp_ready;
  assign illegal   = cmd_funct[3] && (cmd_funct != 4'hF);
  assign op_a      = cmd_use_acc ? acc_q : cmd_a;
  // 9-bit arithmetic: bit 8 is the unsigned carry (ADD) or borrow (SUB).
  assign sum       = {1'b0, op_a} + {1'b0, cmd_b};
  assign diff      = {1'b0, op_a} - {1'b0, cmd_b};

  // ALU datapath: result and flags for the legal operation codes.
  always_comb begin
    alu_res = 8'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (cmd_funct)
      4'd0: begin
        alu_res = sum[7:0];
        alu_c   = sum[8];
        alu_v   = (op_a[7] == cmd_b[7]) && (sum[7] != op_a[7]);
      end
      4'd1: begin
        alu_res = diff[7:0];
        alu_c   = diff[8];
        alu_v   = (op_a[7] != cmd_b[7]) && (diff[7] != op_a[7]);
      end
      4'd2: begin
        alu_res = {op_a[6:0], 1'b0};
        alu_c   = op_a[7];
        alu_v   = op_a[7] ^ op_a[6];
      end
      4'd3: begin
        alu_res = {1'b0, op_a[7:1]};
        alu_c   = op_a[0];
      end
      4'd4:    alu_res = op_a & cmd_b;
      4'd5:    alu_res = op_a | cmd_b;
      4'd6:    alu_res = op_a ^ cmd_b;
      4'd7:    alu_res = ~op_a;
      default: alu_res = 8'd0;
    endcase
  end

  // Next-state: FSM transition, response capture, accumulator and counter.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    acc_d       = acc_q;
    // The drained response is counted even when a new one replaces it.
    if (drain && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (accept) begin
      rsp_valid_d = 1'b1;
      if (cmd_funct == 4'hF) begin
        state_d  = ST_READY;
        result_d = 8'd0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        acc_d    = 8'd0;
      end else if (illegal || (state_q == ST_ERROR)) begin
        // ERROR is sticky until CLR; the accumulator is left untouched.
        state_d  = ST_ERROR;
        result_d = 8'd0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b1;
      end else begin
        state_d  = cmd_funct[2] ? ST_LOGIC : ST_ARITH;
        result_d = alu_res;
        carry_d  = alu_c;
        ovf_d    = alu_v;
        err_d    = 1'b0;
        acc_d    = alu_res;
      end
    end else if (drain) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READY;
      rsp_valid_q <= 1'b0;
      result_q    <= 8'd0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= 8'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;
  assign rsp_state    = state_q;
  assign acc          = acc_q;
  assign op_count     = cnt_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 cmd_funct  in  4  operation code: 0 ADD, 1 SUB, 2 SHFTL, 3 SHFTR, 4 AND, 5 OR, 6 XOR, 7 NOT, 15 CLR, 8-14 illegal.
REQ-007 cmd_a, cmd_b  in  8 each  signed two's-complement operands.
REQ-008 cmd_use_acc  in  1  when 1, the accumulator replaces cmd_a as operand A.
REQ-009 rsp_valid  out  1  response held; rsp_ready  in  1  consumer accepts.
REQ-010 rsp_result  out  8  result; rsp_carry, rsp_overflow, rsp_error  out  1 each  flags.
REQ-011 rsp_state  out  2  FSM state after the command: 0 READY, 1 ARITH, 2 LOGIC, 3 ERROR.
REQ-012 acc  out  8  accumulator register; op_count  out  8  completed-response counter.

Function
REQ-013 cmd_ready SHALL equal !rsp_valid || rsp_ready, combinationally; no other term.
REQ-014 Latency SHALL be one cycle: a command accepted at edge N has rsp_valid=1 and its fields registered after edge N.
REQ-015 rsp_valid SHALL clear at an edge where rsp_ready=1 and no new command is accepted; rsp_* fields SHALL hold stable while rsp_valid && !rsp_ready.
REQ-016 Operand A = cmd_use_acc ? acc : cmd_a, sampled at the accepting edge.
REQ-017 ADD: result = A+B mod 256; carry = bit 8 of unsigned sum; overflow = signed overflow.
REQ-018 SUB: result = A-B mod 256; carry = unsigned borrow (A<B unsigned); overflow = signed overflow.
REQ-019 SHFTL: result = A<<1, zero fill; carry = A[7]; overflow = A[7]^A[6]. SHFTR: logical A>>1; carry = A[0]; overflow = 0.
REQ-020 AND/OR/XOR: bitwise A,B; NOT: ~A; carry = overflow = 0 for all four.
REQ-021 FSM (state reg = rsp_state source): in READY/ARITH/LOGIC, accepted funct 0-3 -> ARITH, 4-7 -> LOGIC, 8-14 -> ERROR, 15 -> READY.
REQ-022 In ERROR: accepted funct 15 -> READY; any other funct stays in ERROR.
REQ-023 rsp_error SHALL be 1 for an illegal funct, or for any non-CLR command accepted while in ERROR; then result, carry, overflow = 0 and acc is unchanged.
REQ-024 CLR: acc <= 0, result = 0, flags = 0, rsp_error = 0, from any state.
REQ-025 Each non-error, non-CLR command SHALL write its result into acc at the accepting edge; back-to-back commands with cmd_use_acc see the updated acc.
REQ-026 op_count SHALL increment by 1 on each rsp_valid && rsp_ready edge, saturating at 255; CLR does not clear it.
REQ-027 Simultaneous response drain and new accept SHALL replace the response with no bubble and count the drained response.

Reset
REQ-028 While rst=1, independent of clk: rsp_valid=0, rsp_result=0, all flags 0, rsp_state=READY, acc=0, op_count=0.
REQ-029 Reset mid-transaction SHALL discard the pending response with no partial update; cmd_ready=1 on the first cycle after release.

Verification
REQ-030 A=24, B=6, funct 0,1,2,3,4,5,6,7 back-to-back, rsp_ready=1 -> results 30,18,48,12,0,30,30,231 (0xE7); states ARITH x4 then LOGIC x4; op_count 8.
REQ-031 ADD 100+100 -> result 0xC8 (-56), overflow=1, carry=0; SUB 0-1 -> 0xFF, carry=1, overflow=0; ADD 0xFF+0x01 -> 0x00, carry=1.
REQ-032 ADD 5+3, then ADD cmd_use_acc=1 with B=2, consecutive cycles -> results 8 then 10; acc=10.
REQ-033 funct 9 -> rsp_error=1, state ERROR; then ADD 1+1 -> rsp_error=1, acc unchanged; then CLR -> state READY, acc=0.
REQ-034 rsp_ready=0 for 3 cycles with the response valid -> cmd_ready=0, rsp fields stable, op_count unchanged; raising rsp_ready with a new command pending -> accepted on the same edge.
REQ-035 rst asserted asynchronously between edges while rsp_valid=1 -> all outputs at reset values immediately, before the next edge.
